// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE exception flag bit positions and fflags CSR
// operation encodings, plus the CSR read-modify-write helper.
package fpu_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam int FLAG_W  = FLAG_NV + 1;

  typedef logic [FLAG_W-1:0] fflags_t;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // Architectural flags after a CSR access; identity when no access occurs.
  function automatic fflags_t csr_apply(input fflags_t cur, input logic en,
                                        input csr_op_e op, input fflags_t wdata);
    fflags_t res;
    res = cur;
    if (en) begin
      unique case (op)
        CSR_WRITE: res = wdata;
        CSR_SET:   res = cur | wdata;
        CSR_CLEAR: res = cur & ~wdata;
        default:   res = cur;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/flag_fifo.sv
// In-order FIFO of pending flag bundles; wrap-bit pointers distinguish full
// from empty. Flush discards every entry after any same-cycle pop is taken.
module flag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CNT_FULL);
  assign empty   = (wr_ptr == rd_ptr);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fflags_acc.sv
// Accumulates FPU exception flag bundles in program order and folds each into
// the sticky architectural fflags on commit, merged with CSR accesses.
module fflags_acc
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     FlgValid,
  output logic                     FlgReady,
  input  logic [FLAG_W-1:0]        Flg,
  input  logic                     Commit,
  input  logic                     Flush,
  input  logic                     CsrEn,
  input  logic [1:0]               CsrOp,
  input  logic [FLAG_W-1:0]        CsrWData,
  output logic [FLAG_W-1:0]        FFlags,
  output logic [$clog2(DEPTH):0]   PendCnt,
  output logic                     CommitErr
);

  logic    fifo_full, fifo_empty;
  logic    push, pop;
  fflags_t head;
  fflags_t flags_nxt;

  // Ready is held low during reset and while flushing; a same-cycle pop
  // does not open a slot.
  assign FlgReady = reset_n & ~fifo_full & ~Flush;
  assign push     = FlgValid & FlgReady;
  assign pop      = Commit & ~fifo_empty;

  flag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLAG_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (Flg),
    .pop     (pop),
    .flush   (Flush),
    .rdata   (head),
    .count   (PendCnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: combinational logic uses blocking '=' with a default first; state uses '<='.
  always_comb begin
    flags_nxt = csr_apply(FFlags, CsrEn, csr_op_e'(CsrOp), CsrWData);
    if (pop) flags_nxt = flags_nxt | head;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      FFlags    <= '0;
      CommitErr <= 1'b0;
    end else begin
      FFlags    <= flags_nxt;
      CommitErr <= Commit & fifo_empty;
    end
  end

endmodule

// File: tb/tb_fflags_acc.sv
// Self-checking bench for fflags_acc: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_fflags_acc;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          FlgValid, FlgReady, Commit, Flush, CsrEn, CommitErr;
  logic [4:0]    Flg, CsrWData, FFlags;
  logic [1:0]    CsrOp;
  logic [CW-1:0] PendCnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0] mq[$];
  logic [4:0] m_ff;
  logic       m_err;

  fflags_acc #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .FlgValid  (FlgValid),
    .FlgReady  (FlgReady),
    .Flg       (Flg),
    .Commit    (Commit),
    .Flush     (Flush),
    .CsrEn     (CsrEn),
    .CsrOp     (CsrOp),
    .CsrWData  (CsrWData),
    .FFlags    (FFlags),
    .PendCnt   (PendCnt),
    .CommitErr (CommitErr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] csr_model(input logic [4:0] cur, input logic en,
                                          input logic [1:0] op, input logic [4:0] wd);
    if (!en || op == 2'd0) return cur;
    if (op == 2'd1) return wd;
    if (op == 2'd2) return cur | wd;
    return cur & ~wd;
  endfunction

  // One clock cycle: drive inputs, check ready, advance model, check outputs.
  task automatic step(input logic v, input logic [4:0] f, input logic c, input logic fl,
                      input logic ce, input logic [1:0] op, input logic [4:0] wd);
    logic       exp_rdy;
    logic [4:0] nff;
    FlgValid = v; Flg = f; Commit = c; Flush = fl;
    CsrEn = ce; CsrOp = op; CsrWData = wd;
    #1;
    exp_rdy = (mq.size() < DEPTH) && !fl;
    check("ready", 8'(FlgReady), 8'(exp_rdy));
    nff   = csr_model(m_ff, ce, op, wd);
    m_err = c && (mq.size() == 0);
    if (c && mq.size() > 0) begin
      nff = nff | mq[0];
      void'(mq.pop_front());
    end
    if (fl) mq.delete();
    else if (v && exp_rdy) mq.push_back(f);
    m_ff = nff;
    @(posedge clk);
    #1;
    check("fflags", 8'(FFlags), 8'(m_ff));
    check("pendcnt", 8'(PendCnt), 8'(mq.size()));
    check("commiterr", 8'(CommitErr), 8'(m_err));
  endtask

  task automatic idle();          step(0, 5'd0, 0, 0, 0, 2'd0, 5'd0); endtask
  task automatic push(input logic [4:0] f); step(1, f, 0, 0, 0, 2'd0, 5'd0); endtask
  task automatic commit();        step(0, 5'd0, 1, 0, 0, 2'd0, 5'd0); endtask
  task automatic flush();         step(0, 5'd0, 0, 1, 0, 2'd0, 5'd0); endtask
  task automatic csr(input logic [1:0] op, input logic [4:0] wd);
    step(0, 5'd0, 0, 0, 1, op, wd);
  endtask

  initial begin
    logic [4:0] or_all;
    logic [4:0] f;
    reset_n = 1'b0;
    FlgValid = 0; Flg = 0; Commit = 0; Flush = 0; CsrEn = 0; CsrOp = 0; CsrWData = 0;
    mq.delete(); m_ff = 5'd0; m_err = 1'b0;
    #1;
    check("rst_fflags", 8'(FFlags), 8'd0);
    check("rst_pend", 8'(PendCnt), 8'd0);
    check("rst_err", 8'(CommitErr), 8'd0);
    check("rst_ready", 8'(FlgReady), 8'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Two bundles committed in order accumulate stickily
    push(5'b00001);
    push(5'b00100);
    check("two_pend", 8'(PendCnt), 8'd2);
    commit();
    check("first_commit", 8'(FFlags), 8'b00001);
    check("one_pend", 8'(PendCnt), 8'd1);
    commit();
    check("second_commit", 8'(FFlags), 8'b00101);
    check("zero_pend", 8'(PendCnt), 8'd0);

    // Fill to DEPTH, hold valid: no extra push; one commit reopens ready
    for (int i = 0; i < DEPTH; i++) push(5'(i + 1));
    check("full_ready", 8'(FlgReady), 8'd0);
    step(1, 5'b11111, 0, 0, 0, 2'd0, 5'd0);
    check("full_hold", 8'(PendCnt), 8'(DEPTH));
    step(1, 5'b11111, 1, 0, 0, 2'd0, 5'd0);
    check("after_pop_ready", 8'(FlgReady), 8'd1);
    flush();

    // CSR clear of a bit re-set by the bundle committed in the same cycle
    csr(2'b01, 5'b10101);
    push(5'b10000);
    step(0, 5'd0, 1, 0, 1, 2'b11, 5'b10000);
    check("clear_vs_commit", 8'(FFlags), 8'b10101);

    // Commit + Flush together, then a commit with nothing pending
    csr(2'b01, 5'b00000);
    push(5'b01000);
    push(5'b00010);
    push(5'b00001);
    step(0, 5'd0, 1, 1, 0, 2'd0, 5'd0);
    check("flush_fflags", 8'(FFlags), 8'b01000);
    check("flush_pend", 8'(PendCnt), 8'd0);
    commit();
    check("err_pulse", 8'(CommitErr), 8'd1);
    check("err_fflags", 8'(FFlags), 8'b01000);
    idle();
    check("err_one_cycle", 8'(CommitErr), 8'd0);

    // Asynchronous reset mid-stream
    csr(2'b01, 5'b11111);
    push(5'b00110);
    push(5'b01001);
    reset_n = 1'b0;
    #1;
    check("arst_fflags", 8'(FFlags), 8'd0);
    check("arst_pend", 8'(PendCnt), 8'd0);
    check("arst_err", 8'(CommitErr), 8'd0);
    check("arst_ready", 8'(FlgReady), 8'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mq.delete(); m_ff = 5'd0; m_err = 1'b0;
    commit();
    check("arst_no_survivor", 8'(FFlags), 8'd0);

    // Push/commit pairs through pointer wrap
    or_all = 5'd0;
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      f = 5'($urandom);
      or_all = or_all | f;
      push(f);
      check("wrap_bound", 8'(PendCnt <= DEPTH), 8'd1);
      commit();
    end
    check("wrap_or", 8'(FFlags), 8'(or_all));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 5'($urandom), ($urandom % 3) == 0, ($urandom % 20) == 0,
           ($urandom % 5) == 0, 2'($urandom), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
